// File: rtl/im_arbiter.sv
// im_arbiter: shares one single-port instruction memory between the CPU fetch port and a loader/debug port.
// Build option IM_ARB_LOAD_PRIO_EN: the loader always wins contention instead of round-robin.
module im_arbiter #(
  parameter int data_size    = 32,
  parameter int mem_size_bit = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    f_req,
  input  logic [mem_size_bit-1:0] f_addr,
  output logic                    f_gnt,
  output logic                    f_rvalid,
  output logic [data_size-1:0]    f_rdata,
  input  logic                    l_req,
  input  logic                    l_we,
  input  logic [mem_size_bit-1:0] l_addr,
  input  logic [data_size-1:0]    l_wdata,
  output logic                    l_gnt,
  output logic                    l_rvalid,
  output logic [data_size-1:0]    l_rdata,
  output logic                    IM_enable,
  output logic                    IM_read,
  output logic                    IM_write,
  output logic [mem_size_bit-1:0] IM_address,
  output logic [data_size-1:0]    IMin,
  input  logic [data_size-1:0]    IMout
);

  logic f_tag_r;
  logic l_tag_r;

`ifdef IM_ARB_LOAD_PRIO_EN
  // Fixed priority: fetch only gets the memory when the loader is idle.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (l_req) begin
      l_gnt = 1'b1;
    end else if (f_req) begin
      f_gnt = 1'b1;
    end else begin
      f_gnt = 1'b0;
    end
  end
`else
  typedef enum logic {
    PORT_FETCH  = 1'b0,
    PORT_LOADER = 1'b1
  } port_e;

  port_e last_winner_r;
  port_e last_winner_nxt_s;

  // Round-robin pointer register; reset favours fetch on the first contention.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_winner_r <= PORT_LOADER;
    end else begin
      last_winner_r <= last_winner_nxt_s;
    end
  end

  // Grant decision and pointer update; the pointer moves only when a grant is given.
  always_comb begin
    f_gnt             = 1'b0;
    l_gnt             = 1'b0;
    last_winner_nxt_s = last_winner_r;
    if (f_req && l_req) begin
      if (last_winner_r == PORT_LOADER) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = 1'b1;
      end
    end else if (f_req) begin
      f_gnt = 1'b1;
    end else if (l_req) begin
      l_gnt = 1'b1;
    end else begin
      f_gnt = 1'b0;
    end
    if (f_gnt) begin
      last_winner_nxt_s = PORT_FETCH;
    end else if (l_gnt) begin
      last_winner_nxt_s = PORT_LOADER;
    end else begin
      last_winner_nxt_s = last_winner_r;
    end
  end
`endif

  // Memory command issue: strobes follow the grant of the previous cycle; address and write data hold when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IM_enable  <= 1'b0;
      IM_read    <= 1'b0;
      IM_write   <= 1'b0;
      IM_address <= '0;
      IMin       <= '0;
    end else begin
      IM_enable <= f_gnt | l_gnt;
      IM_read   <= f_gnt | (l_gnt & ~l_we);
      IM_write  <= l_gnt & l_we;
      if (f_gnt) begin
        IM_address <= f_addr;
      end else if (l_gnt) begin
        IM_address <= l_addr;
      end else begin
        IM_address <= IM_address;
      end
      if (l_gnt) begin
        IMin <= l_wdata;
      end else begin
        IMin <= IMin;
      end
    end
  end

  // Read-source tags: stage one marks the cycle the read is on the memory, stage two is the rvalid pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_tag_r  <= 1'b0;
      l_tag_r  <= 1'b0;
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      f_tag_r  <= f_gnt;
      l_tag_r  <= l_gnt & ~l_we;
      f_rvalid <= f_tag_r;
      l_rvalid <= l_tag_r;
    end
  end

  assign f_rdata = IMout;
  assign l_rdata = IMout;

endmodule

// File: tb/tb_im_arbiter.sv
// Bench for im_arbiter: a bench-side memory, a transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_im_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          f_req   = 1'b0;
  logic [AW-1:0] f_addr  = '0;
  logic          l_req   = 1'b0;
  logic          l_we    = 1'b0;
  logic [AW-1:0] l_addr  = '0;
  logic [DW-1:0] l_wdata = '0;
  logic [DW-1:0] IMout   = '0;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] f_rdata, l_rdata, IMin;
  logic          IM_enable, IM_read, IM_write;
  logic [AW-1:0] IM_address;

  int checks   = 0;
  int failures = 0;

  im_arbiter #(.data_size(DW), .mem_size_bit(AW)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
    .IM_address(IM_address), .IMin(IMin), .IMout(IMout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Power-up memory contents; address 7 is preloaded with a known word.
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 7) return 32'h12345678;
    return (32'(a) * 32'h9E3779B9) ^ 32'h0F0F1234;
  endfunction

  // Single-port synchronous memory: read data appears the cycle after the read strobe is sampled.
  bit [DW-1:0] mem [DEPTH];
  bit          mem_seen [DEPTH];
  always @(posedge clock) begin
    if (IM_enable && IM_write) begin
      mem[IM_address]      = IMin;
      mem_seen[IM_address] = 1'b1;
    end
    if (IM_enable && IM_read)
      IMout <= mem_seen[IM_address] ? mem[IM_address] : init_val(int'(IM_address));
  end

  // Reference model state: the access expected on the memory this cycle, and the read return due this cycle.
  bit            m_last_loader = 1'b1;
  bit            e_en = 1'b0, e_rd = 1'b0, e_wr = 1'b0, e_src_f = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd   = '0;
  bit            rv_f = 1'b0, rv_l = 1'b0;
  logic [DW-1:0] rv_d = '0;
  int            f_wait = 0, l_wait = 0;
  bit [DW-1:0]   mem_m [DEPTH];
  bit            mem_m_seen [DEPTH];

  always @(negedge clock) begin : compare_proc
    bit            gf, gl, nf, nl;
    logic [DW-1:0] nd;
    if (reset) begin
      chk("rst_strobes", 64'({IM_enable, IM_read, IM_write, f_rvalid, l_rvalid}), 64'd0);
      chk("rst_address", 64'(IM_address), 64'd0);
      chk("rst_imin", 64'(IMin), 64'd0);
      m_last_loader = 1'b1;
      e_en = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_src_f = 1'b0;
      e_addr = '0; e_wd = '0;
      rv_f = 1'b0; rv_l = 1'b0;
      f_wait = 0; l_wait = 0;
    end else begin
      chk("im_enable", 64'(IM_enable), 64'(e_en));
      chk("im_read", 64'(IM_read), 64'(e_rd));
      chk("im_write", 64'(IM_write), 64'(e_wr));
      chk("im_address", 64'(IM_address), 64'(e_addr));
      chk("imin", 64'(IMin), 64'(e_wd));
      chk("f_rvalid", 64'(f_rvalid), 64'(rv_f));
      chk("l_rvalid", 64'(l_rvalid), 64'(rv_l));
      if (rv_f) chk("f_rdata", 64'(f_rdata), 64'(rv_d));
      if (rv_l) chk("l_rdata", 64'(l_rdata), 64'(rv_d));
      // the access on the memory this cycle produces next cycle's return
      nf = e_en && e_rd && e_src_f;
      nl = e_en && e_rd && !e_src_f;
      nd = mem_m_seen[e_addr] ? mem_m[e_addr] : init_val(int'(e_addr));
      if (e_en && e_wr) begin
        mem_m[e_addr]      = e_wd;
        mem_m_seen[e_addr] = 1'b1;
      end
      rv_f = nf; rv_l = nl; rv_d = nd;
`ifdef IM_ARB_LOAD_PRIO_EN
      gl = l_req;
      gf = f_req && !l_req;
`else
      if (f_req && l_req) begin
        gf = m_last_loader;
        gl = !m_last_loader;
      end else begin
        gf = f_req;
        gl = l_req;
      end
      if (f_req) begin
        f_wait = f_gnt ? 0 : f_wait + 1;
        chk("f_wait_bound", 64'(f_wait < 2), 64'd1);
      end else f_wait = 0;
      if (l_req) begin
        l_wait = l_gnt ? 0 : l_wait + 1;
        chk("l_wait_bound", 64'(l_wait < 2), 64'd1);
      end else l_wait = 0;
`endif
      chk("f_gnt", 64'(f_gnt), 64'(gf));
      chk("l_gnt", 64'(l_gnt), 64'(gl));
      if (gf) begin
        e_en = 1'b1; e_rd = 1'b1; e_wr = 1'b0; e_src_f = 1'b1;
        e_addr = f_addr; m_last_loader = 1'b0;
      end else if (gl) begin
        e_en = 1'b1; e_rd = !l_we; e_wr = l_we; e_src_f = 1'b0;
        e_addr = l_addr; e_wd = l_wdata; m_last_loader = 1'b1;
      end else begin
        e_en = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [1:0]    seq [4];
    bit            lv [4];
    logic [DW-1:0] ld [4];
    int            fvcount;
    bit            fg, lg;

    cyc(); cyc();
    reset = 1'b0;

    // First request after release is granted; then an async reset mid-cycle clears outputs at once.
    f_req = 1'b1; f_addr = 10'd3;
    #1 chk("first_f_gnt", 64'(f_gnt), 64'd1);
    cyc(); f_req = 1'b0;
    chk("pre_rst_addr", 64'(IM_address), 64'd3);
    #2 reset = 1'b1;
    #1 chk("async_rst_strobes", 64'({IM_enable, IM_read, IM_write, f_rvalid, l_rvalid}), 64'd0);
    chk("async_rst_addr", 64'(IM_address), 64'd0);
    chk("async_rst_imin", 64'(IMin), 64'd0);
    cyc(); reset = 1'b0;

    // Loader write of 0xDEADBEEF to address 5.
    l_req = 1'b1; l_we = 1'b1; l_addr = 10'd5; l_wdata = 32'hDEADBEEF;
    #1 chk("lw_gnt", 64'(l_gnt), 64'd1);
    cyc(); l_req = 1'b0; l_we = 1'b0;
    chk("lw_en", 64'(IM_enable), 64'd1);
    chk("lw_write", 64'(IM_write), 64'd1);
    chk("lw_read", 64'(IM_read), 64'd0);
    chk("lw_addr", 64'(IM_address), 64'd5);
    chk("lw_imin", 64'(IMin), 64'hDEADBEEF);
    cyc();
    chk("lw_no_rvalid", 64'(l_rvalid), 64'd0);

    // Fetch read of address 5 returns the written word two cycles after grant, for one cycle.
    f_req = 1'b1; f_addr = 10'd5;
    cyc(); f_req = 1'b0;
    chk("fr_read", 64'(IM_read), 64'd1);
    chk("fr_addr", 64'(IM_address), 64'd5);
    chk("fr_early", 64'(f_rvalid), 64'd0);
    cyc();
    chk("fr_rvalid", 64'(f_rvalid), 64'd1);
    chk("fr_rdata", 64'(f_rdata), 64'hDEADBEEF);
    chk("fr_l_quiet", 64'(l_rvalid), 64'd0);
    cyc();
    chk("fr_pulse_end", 64'(f_rvalid), 64'd0);

    // Contention straight after reset.
    #2 reset = 1'b1;
    cyc(); reset = 1'b0;
    f_req = 1'b1; f_addr = 10'd11; l_req = 1'b1; l_we = 1'b0; l_addr = 10'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      seq[i] = {f_gnt, l_gnt};
      lv[i]  = l_rvalid;
      ld[i]  = l_rdata;
      cyc();
    end
    f_req = 1'b0; l_req = 1'b0;
`ifdef IM_ARB_LOAD_PRIO_EN
    for (int i = 0; i < 4; i++) chk("prio_seq", 64'(seq[i]), 64'b01);
    chk("prio_l_rvalid", 64'(lv[2]), 64'd1);
    chk("prio_l_rdata", 64'(ld[2]), 64'h12345678);
`else
    chk("rr_seq0", 64'(seq[0]), 64'b10);
    chk("rr_seq1", 64'(seq[1]), 64'b01);
    chk("rr_seq2", 64'(seq[2]), 64'b10);
    chk("rr_seq3", 64'(seq[3]), 64'b01);
    chk("rr_l_rvalid_early", 64'(lv[2]), 64'd0);
    chk("rr_l_rvalid", 64'(lv[3]), 64'd1);
    chk("rr_l_rdata", 64'(ld[3]), 64'h12345678);
`endif

    // Write then immediate fetch of the same address sees the new data.
    l_req = 1'b1; l_we = 1'b1; l_addr = 10'd9; l_wdata = 32'hA5A5A5A5;
    cyc(); l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 10'd9;
    cyc(); f_req = 1'b0;
    cyc();
    chk("raw_rvalid", 64'(f_rvalid), 64'd1);
    chk("raw_rdata", 64'(f_rdata), 64'hA5A5A5A5);

    // Reset while a fetch read is in flight: strobes drop at once and the read never returns.
    f_req = 1'b1; f_addr = 10'd20;
    cyc(); f_req = 1'b0;
    chk("inflight_en", 64'(IM_enable), 64'd1);
    #2 reset = 1'b1;
    #1 chk("inflight_rst_en", 64'(IM_enable), 64'd0);
    fvcount = 0;
    for (int i = 0; i < 3; i++) begin
      #1 fvcount += int'(f_rvalid);
      cyc();
    end
    reset = 1'b0;
    cyc(); cyc();
    fvcount += int'(f_rvalid);
    chk("inflight_dropped", 64'(fvcount), 64'd0);

    // Randomized traffic honouring the hold-until-grant handshake, with rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      fg = f_gnt;
      lg = l_gnt;
      @(posedge clock);
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (!f_req || fg) begin
        f_req  = ($urandom_range(0, 2) != 0);
        f_addr = AW'($urandom_range(0, 15));
      end
      if (!l_req || lg) begin
        l_req   = ($urandom_range(0, 2) != 0);
        l_we    = ($urandom_range(0, 1) != 0);
        l_addr  = AW'($urandom_range(0, 15));
        l_wdata = $urandom;
      end
    end
    f_req = 1'b0; l_req = 1'b0;
    cyc(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
